pwm_sequencer: RTL and testbench

Autonomous duty-cycle sequencer for the counter/timer in PWM mode. Holds an 8-entry duty table and, on each timer top event, writes the next entry into the timer's CMPR0 or CMPR1 register over the timer's register bus. Sits between the CPU and the counter/timer, shares that bus with the CPU, and gives the CPU priority. Exposes its own register window on the CPU bus.

---
 rtl/pwm_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pwm_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sequencer.sv
// Duty-cycle sequencer: steps an 8-entry table into the timer compare register on each top event,
// sharing the timer register bus with the CPU (CPU always has priority).
module pwm_sequencer #(
   parameter logic [7:0] PWM_SEQUENCER_ADDRESS = 8'h10,
   parameter logic [7:0] CT_BASE               = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic [7:0] address,
   input  logic       w_en,
   input  logic       r_en,
   output logic [7:0] dout,
   input  logic [7:0] cpu_ct_address,
   input  logic [7:0] cpu_ct_din,
   input  logic       cpu_ct_w_en,
   input  logic       cpu_ct_r_en,
   output logic [7:0] ct_address,
   output logic [7:0] ct_din,
   output logic       ct_w_en,
   output logic       ct_r_en,
   input  logic       top_flag,
   output logic       done_irq
);

   // state    | meaning
   // S_IDLE   | sequencer stopped, bus fully owned by the CPU
   // S_LOAD   | write of table[idx] pending, issued on first CPU-idle cycle
   // S_WAIT   | write issued, counting top events for the current entry
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

   state_t     state_q;
   logic       loop_q, tgt_q, tgt_lat_q, irq_en_q, done_q, ovr_q, done_irq_q;
   logic [2:0] len_q, ptr_q, idx_q;
   logic [7:0] rep_q, rep_cnt_q, dout_q;
   logic [7:0] tbl_q [8];

   logic [7:0] off;
   logic       in_win, wr_ctrl, wr_len, wr_stat, wr_ptr, wr_data, wr_rep;
   logic       busy, issue, start, abort, rep_done, last;
   logic [7:0] rdata_d;

   always_comb begin
      off      = address - PWM_SEQUENCER_ADDRESS;
      in_win   = (off < 8'd7);
      wr_ctrl  = w_en && in_win && (off[2:0] == 3'd0);
      wr_len   = w_en && in_win && (off[2:0] == 3'd1);
      wr_stat  = w_en && in_win && (off[2:0] == 3'd3);
      wr_ptr   = w_en && in_win && (off[2:0] == 3'd4);
      wr_data  = w_en && in_win && (off[2:0] == 3'd5);
      wr_rep   = w_en && in_win && (off[2:0] == 3'd6);
      busy     = (state_q != S_IDLE);
      // Gated by rst so a reset cycle in LOAD never leaks a write onto the bus.
      issue    = rst && (state_q == S_LOAD) && !cpu_ct_w_en && !cpu_ct_r_en;
      start    = wr_ctrl && din[0] && !busy;
      abort    = wr_ctrl && !din[0] && busy;
      rep_done = (rep_cnt_q >= rep_q);
      last     = (idx_q >= len_q);
   end

   always_comb begin
      ct_address = issue ? (CT_BASE + 8'd3 + {7'b0, tgt_lat_q}) : cpu_ct_address;
      ct_din     = issue ? tbl_q[idx_q] : cpu_ct_din;
      ct_w_en    = issue ? 1'b1 : cpu_ct_w_en;
      ct_r_en    = issue ? 1'b0 : cpu_ct_r_en;
   end

   always_comb begin
      rdata_d = 8'h00;
      case (off[2:0])
         3'd0: rdata_d = {4'b0, irq_en_q, tgt_q, loop_q, busy};
         3'd1: rdata_d = {5'b0, len_q};
         3'd2: rdata_d = {5'b0, idx_q};
         3'd3: rdata_d = {5'b0, ovr_q, done_q, busy};
         3'd4: rdata_d = {5'b0, ptr_q};
         3'd5: rdata_d = tbl_q[ptr_q];
         3'd6: rdata_d = rep_q;
         default: rdata_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         loop_q     <= 1'b0;
         tgt_q      <= 1'b0;
         tgt_lat_q  <= 1'b0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         done_irq_q <= 1'b0;
         len_q      <= 3'd0;
         ptr_q      <= 3'd0;
         idx_q      <= 3'd0;
         rep_q      <= 8'd0;
         rep_cnt_q  <= 8'd0;
         dout_q     <= 8'd0;
         for (int i = 0; i < 8; i++) tbl_q[i] <= 8'd0;
      end else begin
         done_irq_q <= 1'b0;
         if (wr_ctrl) begin
            loop_q   <= din[1];
            tgt_q    <= din[2];
            irq_en_q <= din[3];
         end
         if (wr_len) len_q <= din[2:0];
         if (wr_ptr) ptr_q <= din[2:0];
         if (wr_data) begin
            tbl_q[ptr_q] <= din;
            ptr_q        <= ptr_q + 3'd1;
         end
         if (wr_rep) rep_q <= din;
         if (wr_stat) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  tgt_lat_q <= din[2];
                  idx_q     <= 3'd0;
                  rep_cnt_q <= 8'd0;
                  state_q   <= S_LOAD;
               end
            end
            default: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else begin
                  if (issue) state_q <= S_WAIT;
                  if (top_flag) begin
                     if (!rep_done) begin
                        rep_cnt_q <= rep_cnt_q + 8'd1;
                     end else begin
                        rep_cnt_q <= 8'd0;
                        if (!last || loop_q) begin
                           idx_q   <= last ? 3'd0 : idx_q + 3'd1;
                           state_q <= S_LOAD;
                           // Pending write superseded by the newer entry.
                           if ((state_q == S_LOAD) && !issue) ovr_q <= 1'b1;
                        end else begin
                           state_q    <= S_IDLE;
                           done_q     <= 1'b1;
                           done_irq_q <= irq_en_q;
                        end
                     end
                  end
               end
            end
         endcase

         if (!in_win)   dout_q <= 8'd0;
         else if (r_en) dout_q <= rdata_d;
      end
   end

   assign dout     = dout_q;
   assign done_irq = done_irq_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: expected timer-bus writes are queued as stimulus is driven and
// popped by a bus monitor; register readback and pulse timing are checked inline per scenario.
module tb_pwm_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din, address, dout;
   logic       w_en, r_en;
   logic [7:0] cpu_ct_address, cpu_ct_din;
   logic       cpu_ct_w_en, cpu_ct_r_en;
   logic [7:0] ct_address, ct_din;
   logic       ct_w_en, ct_r_en;
   logic       top_flag, done_irq;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q [$];

   pwm_sequencer dut (
      .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
      .dout(dout), .cpu_ct_address(cpu_ct_address), .cpu_ct_din(cpu_ct_din),
      .cpu_ct_w_en(cpu_ct_w_en), .cpu_ct_r_en(cpu_ct_r_en), .ct_address(ct_address),
      .ct_din(ct_din), .ct_w_en(ct_w_en), .ct_r_en(ct_r_en), .top_flag(top_flag),
      .done_irq(done_irq)
   );

   always #5 clk = ~clk;

   // Every write on the timer bus must match the head of the expectation queue.
   always @(negedge clk) begin
      if (ct_w_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ct_write_unexpected got addr=%h data=%h, required none", ct_address, ct_din);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({ct_address, ct_din} !== e) begin
               errors++;
               $display("FAIL ct_write got addr=%h data=%h, required addr=%h data=%h",
                        ct_address, ct_din, e[15:8], e[7:0]);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      address = a;
      din     = d;
      w_en    = 1'b1;
      @(posedge clk);
      #1;
      w_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      address = a;
      r_en    = 1'b1;
      @(posedge clk);
      #1;
      r_en = 1'b0;
      d    = dout;
   endtask

   task automatic top();
      top_flag = 1'b1;
      @(posedge clk);
      #1;
      top_flag = 1'b0;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_writes got %0d pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      logic [7:0] v;
      checks++;
      if (dout !== 8'h00 || done_irq !== 1'b0 || ct_w_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got dout=%h irq=%b ct_w_en=%b, required 00 0 0", dout, done_irq, ct_w_en);
      end
      rd(8'h13, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL reset_status got %h, required 00", v); end
      rd(8'h16, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL reset_repeat got %h, required 00", v); end
   endtask

   task automatic test_basic();
      logic [7:0] v;
      wr(8'h14, 8'd0);
      wr(8'h15, 8'd10);
      wr(8'h15, 8'd20);
      wr(8'h15, 8'd30);
      wr(8'h11, 8'd2);
      wr(8'h16, 8'd0);
      push(8'h03, 8'd10);
      wr(8'h10, 8'h09);
      checks++;
      if (ct_w_en !== 1'b1 || ct_din !== 8'd10) begin
         errors++;
         $display("FAIL basic_start_latency got w_en=%b data=%0d, required 1 10", ct_w_en, ct_din);
      end
      idle(2);
      push(8'h03, 8'd20); top(); idle(2);
      push(8'h03, 8'd30); top(); idle(2);
      top();
      checks++;
      if (done_irq !== 1'b1) begin errors++; $display("FAIL basic_irq got %b, required 1", done_irq); end
      idle(1);
      checks++;
      if (done_irq !== 1'b0) begin errors++; $display("FAIL basic_irq_width got %b, required 0", done_irq); end
      rd(8'h13, v);
      checks++;
      if (v !== 8'h02) begin errors++; $display("FAIL basic_status got %h, required 02", v); end
      rd(8'h12, v);
      checks++;
      if (v !== 8'h02) begin errors++; $display("FAIL basic_index got %h, required 02", v); end
      rd(8'h10, v);
      checks++;
      if (v !== 8'h08) begin errors++; $display("FAIL basic_ctrl got %h, required 08", v); end
      idle(1);
      checks++;
      if (dout !== 8'h08) begin errors++; $display("FAIL dout_hold got %h, required 08", dout); end
      address = 8'h20;
      idle(1);
      checks++;
      if (dout !== 8'h00) begin errors++; $display("FAIL dout_outside got %h, required 00", dout); end
      wr(8'h13, 8'h00);
      check_drained("basic");
   endtask

   task automatic test_loop_target();
      logic [7:0] v;
      wr(8'h14, 8'd0);
      wr(8'h15, 8'd5);
      wr(8'h15, 8'd6);
      wr(8'h11, 8'd1);
      push(8'h04, 8'd5);
      wr(8'h10, 8'h07);
      idle(2);
      for (int k = 1; k <= 5; k++) begin
         push(8'h04, (k % 2 == 1) ? 8'd6 : 8'd5);
         top();
         checks++;
         if (done_irq !== 1'b0) begin errors++; $display("FAIL loop_irq top=%0d got %b, required 0", k, done_irq); end
         idle(2);
      end
      wr(8'h10, 8'h00);
      rd(8'h13, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL loop_abort_status got %h, required 00", v); end
      check_drained("loop");
   endtask

   task automatic test_repeat();
      logic [7:0] v;
      wr(8'h16, 8'd2);
      push(8'h03, 8'd5);
      wr(8'h10, 8'h09);
      idle(2);
      for (int k = 1; k <= 6; k++) begin
         if (k == 3) push(8'h03, 8'd6);
         top();
         checks++;
         if (done_irq !== (k == 6)) begin
            errors++;
            $display("FAIL repeat_irq top=%0d got %b, required %b", k, done_irq, (k == 6));
         end
         idle(2);
      end
      rd(8'h13, v);
      checks++;
      if (v !== 8'h02) begin errors++; $display("FAIL repeat_status got %h, required 02", v); end
      wr(8'h13, 8'h00);
      wr(8'h16, 8'd0);
      check_drained("repeat");
   endtask

   task automatic test_arbitration();
      address     = 8'h10;
      din         = 8'h01;
      w_en        = 1'b1;
      cpu_ct_w_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cpu_ct_address = 8'h40 + 8'(i);
         cpu_ct_din     = 8'hA0 + 8'(i);
         push(cpu_ct_address, cpu_ct_din);
         #1;
         checks++;
         if (ct_address !== (8'h40 + 8'(i)) || ct_din !== (8'hA0 + 8'(i))) begin
            errors++;
            $display("FAIL arb_cpu_pass i=%0d got %h/%h, required %h/%h", i, ct_address, ct_din,
                     8'h40 + 8'(i), 8'hA0 + 8'(i));
         end
         @(posedge clk);
         #1;
         w_en = 1'b0;
      end
      push(8'h03, 8'd5);
      cpu_ct_w_en = 1'b0;
      #1;
      checks++;
      if (ct_w_en !== 1'b1 || ct_address !== 8'h03) begin
         errors++;
         $display("FAIL arb_first_free got w_en=%b addr=%h, required 1 03", ct_w_en, ct_address);
      end
      idle(2);
      cpu_ct_r_en    = 1'b1;
      cpu_ct_address = 8'h07;
      #1;
      checks++;
      if (ct_r_en !== 1'b1 || ct_address !== 8'h07 || ct_w_en !== 1'b0) begin
         errors++;
         $display("FAIL arb_cpu_read got r=%b addr=%h w=%b, required 1 07 0", ct_r_en, ct_address, ct_w_en);
      end
      idle(1);
      cpu_ct_r_en = 1'b0;
      wr(8'h10, 8'h00);
      check_drained("arb");
   endtask

   task automatic test_overrun_abort();
      logic [7:0] v;
      wr(8'h11, 8'd2);
      cpu_ct_r_en    = 1'b1;
      cpu_ct_address = 8'h02;
      wr(8'h10, 8'h01);
      checks++;
      if (ct_w_en !== 1'b0) begin errors++; $display("FAIL ovr_held got w_en=%b, required 0", ct_w_en); end
      top();
      push(8'h03, 8'd6);
      cpu_ct_r_en = 1'b0;
      idle(2);
      rd(8'h13, v);
      checks++;
      if (v !== 8'h05) begin errors++; $display("FAIL ovr_status got %h, required 05", v); end
      rd(8'h12, v);
      checks++;
      if (v !== 8'h01) begin errors++; $display("FAIL ovr_index got %h, required 01", v); end
      wr(8'h10, 8'h00);
      top();
      checks++;
      if (done_irq !== 1'b0) begin errors++; $display("FAIL abort_irq got %b, required 0", done_irq); end
      idle(3);
      rd(8'h13, v);
      checks++;
      if (v !== 8'h04) begin errors++; $display("FAIL abort_status got %h, required 04", v); end
      wr(8'h13, 8'h00);
      check_drained("ovr");
   endtask

   task automatic test_races();
      logic [7:0] v;
      wr(8'h11, 8'd0);
      push(8'h03, 8'd5);
      wr(8'h10, 8'h09);
      idle(2);
      address = 8'h10; din = 8'h00; w_en = 1'b1; top_flag = 1'b1;
      @(posedge clk);
      #1;
      w_en = 1'b0; top_flag = 1'b0;
      checks++;
      if (done_irq !== 1'b0) begin errors++; $display("FAIL race_abort_irq got %b, required 0", done_irq); end
      rd(8'h13, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL race_abort_status got %h, required 00", v); end
      push(8'h03, 8'd5);
      wr(8'h10, 8'h09);
      idle(2);
      address = 8'h13; din = 8'h00; w_en = 1'b1; top_flag = 1'b1;
      @(posedge clk);
      #1;
      w_en = 1'b0; top_flag = 1'b0;
      checks++;
      if (done_irq !== 1'b1) begin errors++; $display("FAIL race_done_irq got %b, required 1", done_irq); end
      rd(8'h13, v);
      checks++;
      if (v !== 8'h02) begin errors++; $display("FAIL race_done_status got %h, required 02", v); end
      wr(8'h13, 8'h00);
      check_drained("race");
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      wr(8'h11, 8'd3);
      rd(8'h11, v);
      checks++;
      if (v !== 8'h03) begin errors++; $display("FAIL len_readback got %h, required 03", v); end
      wr(8'h10, 8'h01);
      rst = 1'b0;
      #1;
      checks++;
      if (ct_w_en !== 1'b0) begin errors++; $display("FAIL rst_load_write got %b, required 0", ct_w_en); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      checks++;
      if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h, required 00", dout); end
      idle(4);
      rd(8'h10, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h, required 00", v); end
      rd(8'h11, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL rst_len got %h, required 00", v); end
      rd(8'h15, v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL rst_table got %h, required 00", v); end
      check_drained("rst");
   endtask

   initial begin
      rst = 1'b0; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
      cpu_ct_address = 8'h00; cpu_ct_din = 8'h00; cpu_ct_w_en = 1'b0; cpu_ct_r_en = 1'b0;
      top_flag = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_loop_target();
      test_repeat();
      test_arbitration();
      test_overrun_abort();
      test_races();
      test_reset_mid();
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
